// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the freq_meter period meter.
`timescale 1ns/1ps
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned MAX_CNT_W = 32;

    // All-ones value of a counter `width` bits wide (width limited to MAX_CNT_W).
    function automatic logic [MAX_CNT_W-1:0] sat_value(input int unsigned width);
        logic [MAX_CNT_W-1:0] one;
        one = 1;
        if (width >= MAX_CNT_W) begin
            return '1;
        end
        return (one << width) - one;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Synchroniser chain for an asynchronous input plus a one-cycle rising-edge strobe.
`timescale 1ns/1ps
module sync_rise #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;

    // SYNC_STAGES must be at least 2 so the slice below is non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/freq_meter.sv
// Period meter: counts clk cycles spanned by 2^AVG_LOG2 rising-edge periods of i_sig.
`timescale 1ns/1ps
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sig,
    input  logic             start,
    output logic             o_busy,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_period,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(sat_value(CNT_W));
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam int unsigned         N_EDGES   = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0]   EDGE_LAST = (AVG_LOG2+1)'(N_EDGES - 1);
    localparam logic [AVG_LOG2:0]   EDGE_ONE  = (AVG_LOG2+1)'(1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [AVG_LOG2:0]  edges;
    logic               rise;

    sync_rise #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sig (i_sig),
        .rise  (rise)
    );

    // start is a level sampled only in IDLE (no ready, nothing queued); o_valid is a
    // single-cycle strobe with no backpressure, and o_period/o_ovf hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            edges    <= '0;
            o_period <= '0;
            o_ovf    <= 1'b0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ARM;
                        count  <= '0;
                        edges  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= MEAS;
                        count <= CNT_ONE;
                    end else if (count == CNT_MAX) begin
                        o_period <= CNT_MAX;
                        o_ovf    <= 1'b1;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                MEAS: begin
                    if (count != CNT_MAX) begin
                        count <= count + CNT_ONE;
                    end
                    // The closing rise wins over saturation on the same cycle.
                    if (rise && edges == EDGE_LAST) begin
                        o_period <= count;
                        o_ovf    <= 1'b0;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        if (rise) begin
                            edges <= edges + EDGE_ONE;
                        end
                        if (count == CNT_MAX) begin
                            o_period <= CNT_MAX;
                            o_ovf    <= 1'b1;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three parameterisations share one stimulus and are checked every cycle.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int NI = 3;
    localparam int S  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic i_sig = 1'b0;
    logic start = 1'b0;

    logic        b0, v0, o0, b1, v1, o1, b2, v2, o2;
    logic [15:0] p0, p1;
    logic [7:0]  p2;

    logic        db[NI];
    logic        dv[NI];
    logic        dovf[NI];
    logic [15:0] dp[NI];

    assign db[0] = b0;  assign dv[0] = v0;  assign dovf[0] = o0;  assign dp[0] = p0;
    assign db[1] = b1;  assign dv[1] = v1;  assign dovf[1] = o1;  assign dp[1] = p1;
    assign db[2] = b2;  assign dv[2] = v2;  assign dovf[2] = o2;  assign dp[2] = {8'h00, p2};

    freq_meter #(.CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .i_sig(i_sig), .start(start),
        .o_busy(b0), .o_valid(v0), .o_period(p0), .o_ovf(o0));
    freq_meter #(.CNT_W(16), .AVG_LOG2(0), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .i_sig(i_sig), .start(start),
        .o_busy(b1), .o_valid(v1), .o_period(p1), .o_ovf(o1));
    freq_meter #(.CNT_W(8), .AVG_LOG2(2), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .i_sig(i_sig), .start(start),
        .o_busy(b2), .o_valid(v2), .o_period(p2), .o_ovf(o2));

    // ---------------- clock / stimulus source ----------------
    always #10 clk = ~clk;

    int sig_period = 2;  // 0 = stuck low, otherwise period in clk cycles
    int ph = 0;
    always @(posedge clk) begin
        if (sig_period == 0) begin
            i_sig <= 1'b0;
            ph    <= 0;
        end else begin
            i_sig <= (ph < sig_period / 2);
            ph    <= (ph >= sig_period - 1) ? 0 : ph + 1;
        end
    end

    // ---------------- behavioural model ----------------
    // Timestamp model: result = edges between first and final synchronised rise,
    // capped at the counter maximum measured from the relevant start point.
    int edge_n = 0;
    bit sig_q[$];
    bit m_busy[NI], m_valid[NI], m_ovf[NI];
    int m_per[NI], m_t0[NI], m_first[NI], m_k[NI];
    int p_max[NI] = '{65535, 65535, 255};
    int p_n[NI]   = '{4, 1, 4};

    function automatic void model_clear();
        sig_q.delete();
        for (int j = 0; j <= S; j++) sig_q.push_back(1'b0);
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_per[i] = 0;
            m_t0[i] = 0; m_first[i] = -1; m_k[i] = 0;
        end
    endfunction

    function automatic void model_finish(input int i, input int per, input bit ovf);
        m_per[i] = per; m_ovf[i] = ovf; m_valid[i] = 1;
    endfunction

    function automatic void model_step(input int i, input bit r, input bit st);
        if (m_valid[i]) begin
            m_valid[i] = 0;
            m_busy[i]  = 0;
        end else if (!m_busy[i]) begin
            if (st) begin
                m_busy[i] = 1; m_t0[i] = edge_n; m_first[i] = -1; m_k[i] = 0;
            end
        end else if (m_first[i] < 0) begin
            if (r) m_first[i] = edge_n;
            else if (edge_n - 1 - m_t0[i] == p_max[i]) model_finish(i, p_max[i], 1);
        end else begin
            if (r) m_k[i]++;
            if (r && m_k[i] == p_n[i]) model_finish(i, edge_n - m_first[i], 0);
            else if (edge_n - m_first[i] == p_max[i]) model_finish(i, p_max[i], 1);
        end
    endfunction

    initial model_clear();
    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        bit r;
        if (rst_n) begin
            r = sig_q[S-1] & ~sig_q[S];
            edge_n++;
            for (int i = 0; i < NI; i++) model_step(i, r, start);
            sig_q.push_front(i_sig);
            void'(sig_q.pop_back());
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    bit running = 1;

    always @(negedge clk) begin
        if (running) begin
            for (int i = 0; i < NI; i++) begin
                logic [15:0] wp;
                wp = 16'(m_per[i]);
                checks++;
                if ({db[i], dv[i], dp[i], dovf[i]} !== {m_busy[i], m_valid[i], wp, m_ovf[i]}) begin
                    errors++;
                    $display("FAIL cycle inst%0d t=%0t: got busy=%b valid=%b period=%0d ovf=%b, want busy=%b valid=%b period=%0d ovf=%b",
                             i, $time, db[i], dv[i], dp[i], dovf[i], m_busy[i], m_valid[i], wp, m_ovf[i]);
                end
            end
        end
    end

    int          cap_cnt[NI];
    logic [15:0] cap_per[NI];
    logic        cap_ovf[NI];
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dv[i] === 1'b1) begin
                cap_cnt[i]++; cap_per[i] = dp[i]; cap_ovf[i] = dovf[i];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check(input string name, input int idx, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d want %0d", name, idx, got, want);
        end
    endtask

    function automatic bit any_busy(input int mask);
        for (int i = 0; i < NI; i++) if (mask[i] && db[i] === 1'b1) return 1;
        return 0;
    endfunction

    task automatic wait_idle(input int mask, input int budget);
        int c;
        c = 0;
        while (c < budget && any_busy(mask)) begin
            tick(1);
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL timeout: mask %b still busy after %0d cycles", mask[2:0], budget);
        end
    endtask

    task automatic clear_caps();
        for (int i = 0; i < NI; i++) begin
            cap_cnt[i] = 0; cap_per[i] = '0; cap_ovf[i] = 1'b0;
        end
    endtask

    task automatic expect_result(input string name, input int i, input int per, input int ovf);
        check({name, "_count"}, i, cap_cnt[i], 1);
        check({name, "_period"}, i, cap_per[i], per);
        check({name, "_ovf"}, i, cap_ovf[i], ovf);
    endtask

    task automatic run_all(input int period, input int budget);
        sig_period = period;
        tick(2 * period + 4);
        clear_caps();
        pulse_start();
        wait_idle(7, budget);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NI; i++) begin
            check({name, "_busy"}, i, db[i], 0);
            check({name, "_valid"}, i, dv[i], 0);
            check({name, "_period"}, i, dp[i], 0);
            check({name, "_ovf"}, i, dovf[i], 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_caps();
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // divide-by-2 source
        run_all(2, 200);
        expect_result("div2", 0, 8, 0);
        expect_result("div2", 1, 2, 0);
        expect_result("div2", 2, 8, 0);

        // 10-cycle period
        run_all(10, 300);
        expect_result("p10", 0, 40, 0);
        expect_result("p10", 1, 10, 0);
        expect_result("p10", 2, 40, 0);

        // 100-cycle period: the 8-bit counter saturates in MEAS
        run_all(100, 900);
        expect_result("p100", 0, 400, 0);
        expect_result("p100", 1, 100, 0);
        expect_result("p100", 2, 255, 1);

        // stuck low: only the 8-bit instance times out in reach
        sig_period = 0;
        tick(4);
        clear_caps();
        pulse_start();
        wait_idle(4, 400);
        expect_result("stuck", 2, 255, 1);
        check("stuck_busy_after", 2, db[2], 0);
        check("stuck_wide_busy", 0, db[0], 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // start during MEAS and during DONE is ignored
        sig_period = 10;
        tick(24);
        clear_caps();
        pulse_start();
        tick(20);
        check("meas_busy", 0, db[0], 1);
        pulse_start();
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                tick(1);
                if (dv[0] === 1'b1) begin
                    seen = 1;
                    start = 1'b1;
                    tick(1);
                    start = 1'b0;
                end
            end
            check("done_seen", 0, seen, 1);
        end
        wait_idle(7, 200);
        expect_result("ign", 0, 40, 0);
        tick(20);
        check("ign_hold_period", 0, dp[0], 40);
        check("ign_hold_count", 0, cap_cnt[0], 1);
        check("ign_idle", 0, db[0], 0);

        // asynchronous reset mid-MEAS, not clock aligned
        sig_period = 2;
        tick(6);
        pulse_start();
        tick(5);
        check("pre_reset_busy", 0, db[0], 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #0.5;
        check_all_zero("async_reset");
        #0.5 rst_n = 1'b1;
        tick(3);
        clear_caps();
        pulse_start();
        wait_idle(7, 200);
        expect_result("post_reset", 0, 8, 0);
        expect_result("post_reset", 1, 2, 0);
        expect_result("post_reset", 2, 8, 0);

        tick(2);
        running = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Period meter that sits directly downstream of the clock divider. It takes the divided clock (or any slow square wave) on `i_sig`, synchronises it into the `clk` domain and counts `clk` cycles across 2^AVG_LOG2 consecutive rising-edge periods of `i_sig`. The result is reported with a one-cycle valid pulse. It is the self-check stage for divider outputs: a divide-by-2 output must read 2·2^AVG_LOG2.

## Interface
- `CNT_W`, default 16: width of the cycle counter and of `o_period`.
- `AVG_LOG2`, default 2: number of periods accumulated = 2^AVG_LOG2. Legal range 0..4.
- `SYNC_STAGES`, default 2: synchroniser depth on `i_sig`, minimum 2.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_sig` in 1: signal under measurement, treated as asynchronous.
- `start` in 1: request a measurement. Sampled only in IDLE.
- `o_busy` out 1: high in ARM, MEAS and DONE.
- `o_valid` out 1: one-cycle pulse when `o_period`/`o_ovf` update.
- `o_period` out CNT_W: `clk` cycles spanned by 2^AVG_LOG2 periods. Held until the next `o_valid`.
- `o_ovf` out 1: last result saturated (too slow, or `i_sig` stuck). Held with `o_period`.

## Operation
- Synchroniser: SYNC_STAGES flops, then one history flop. `rise = sync_q & ~hist`, combinational and one cycle wide.
- State IDLE:
  - `start` = 1 moves to ARM.
  - On that transition, `count` <= 0 and `edges` <= 0.
- State ARM (wait for the first rising edge):
  - `rise` moves to MEAS with `count` <= 1.
  - Otherwise `count` increments.
  - If `count` reaches 2^CNT_W−1 without a rise: `o_period` <= all-ones, `o_ovf` <= 1, go to DONE.
- State MEAS:
  - `count` increments every cycle, including cycles where `rise` is high.
  - On `rise`, `edges` increments.
  - On the rise where `edges` == 2^AVG_LOG2−1 (the old value): `o_period` <= `count` (the value before increment), `o_ovf` <= 0, go to DONE.
  - If `count` == 2^CNT_W−1 and that final rise is absent: saturate (`o_period` all-ones, `o_ovf` = 1), go to DONE.
- State DONE: `o_valid` = 1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE, including during DONE, is ignored. It is not queued.
- Arithmetic:
  - `count` is unsigned CNT_W and never wraps.
  - `edges` is AVG_LOG2+1 bits wide.
  - With AVG_LOG2 = 0, the first MEAS rise ends the measurement.
- Reset, at power-up or mid-operation:
  - State returns to IDLE.
  - Synchroniser and history flops, `count`, `edges`, `o_period`, `o_ovf`, `o_valid` and `o_busy` all go to 0.

## Timing
- `start` high at edge t: `o_busy` = 1 from t+1.
- Synchroniser latency is SYNC_STAGES cycles plus history. The offset is identical at both period ends, so the result is exact for `i_sig` synchronous to `clk`.
- For a steady period of P `clk` cycles: `o_period` = P·2^AVG_LOG2.
- `o_valid` rises one cycle after the final rise. `o_busy` drops the cycle after `o_valid`.
- Total latency from first rise to `o_valid` is P·2^AVG_LOG2 + 1 cycles.
- Minimum measurable period is 2 `clk` cycles. Shorter periods give undefined counts.
- For asynchronous `i_sig`, the result is accurate to ±1 cycle.

## Structure
- `freq_meter_pkg` holds:
  - the state enum (IDLE, ARM, MEAS, DONE);
  - the all-ones saturation constant helper.
- Sub-module `sync_rise`, parameterised by SYNC_STAGES:
  - synchroniser chain, history flop and the `rise` output;
  - same clock and reset as the parent.
- The top level holds the FSM, `count`, `edges` and the output registers.

## Test plan
- `i_sig` driven by a divide-by-2 instance on the same `clk` (50 MHz, 20 ns), AVG_LOG2 = 2, pulse `start` → `o_valid` pulse, `o_period` = 8, `o_ovf` = 0.
- `i_sig` with a 10-cycle period (5 high, 5 low), AVG_LOG2 = 2 → `o_period` = 40. Repeat with AVG_LOG2 = 0 → `o_period` = 10.
- CNT_W = 8, `i_sig` stuck low → after 255 ARM cycles, `o_period` = 255, `o_ovf` = 1, one `o_valid`, `o_busy` low the next cycle.
- CNT_W = 8, `i_sig` period 100, AVG_LOG2 = 2 (400 > 255) → saturates in MEAS: `o_period` = 255, `o_ovf` = 1.
- `start` pulsed in MEAS and in DONE → no extra measurement, exactly one `o_valid`, `o_period` unchanged until the next IDLE `start`.
- `rst_n` low mid-MEAS for 1 ns, not clock-aligned → all outputs 0 immediately. A new `start` after release gives the correct 8 for the div-2 input.
